// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// Memory stage between execute and writeback. Non-memory results pass
// straight through with one cycle of latency. Loads and stores are issued on
// a word-addressed req/ack data bus. Loads return the addressed byte,
// halfword or word, sign- or zero-extended. Stores drive replicated write
// data with matching byte enables. While a transaction is outstanding the
// stage asserts stall. Misaligned accesses never reach the bus and are
// reported with misalign. A transaction that waits too long for dbus_ack is
// abandoned and reported with bus_err.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   in_valid          execute-stage result present
//   in_mem_read       0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU (6-7 none)
//   in_mem_write      0 none, 1 SB, 2 SH, 3 SW (ignored when a load is present)
//   in_reg_write      instruction writes rd
//   in_rd             destination register
//   in_alu_res        ALU result; also the memory byte address
//   in_store_data     rs2 value for stores
//   in_pc             instruction pc
//   stall             upstream must hold its inputs (high while in BUS)
//   dbus_req/we/addr/wdata/be   data bus request, held stable until ack
//   dbus_rdata, dbus_ack        data bus response
//   wb_valid          single-cycle pulse per accepted instruction
//   wb_is_load        wb_mem_data is the result
//   wb_mem_data       extended load data (0 on faults)
//   wb_alu_res, wb_pc, wb_rd    passed through
//   wb_reg_write      in_reg_write, forced 0 on any fault
//   misalign, bus_err fault flags, qualified by wb_valid
//
// Parameter
//   TIMEOUT_CYCLES    BUS cycles to wait for dbus_ack; 0 disables the timeout
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [2:0]  in_mem_read,
    input  logic [1:0]  in_mem_write,
    input  logic        in_reg_write,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_alu_res,
    input  logic [31:0] in_store_data,
    input  logic [31:0] in_pc,
    output logic        stall,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic        wb_valid,
    output logic        wb_is_load,
    output logic [31:0] wb_mem_data,
    output logic [31:0] wb_alu_res,
    output logic [31:0] wb_pc,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        misalign,
    output logic        bus_err
);

    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LH  = 3'd2;
    localparam logic [2:0] LD_LBU = 3'd4;
    localparam logic [2:0] LD_LHU = 3'd5;

    localparam logic [1:0] ST_NONE = 2'd0;
    localparam logic [1:0] ST_SB   = 2'd1;
    localparam logic [1:0] ST_SH   = 2'd2;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Formatting helpers
    // -----------------------------------------------------------------------
    function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_B:    be = 4'b0001 << off;
            SZ_H:    be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0] sz, input logic [31:0] sd);
        logic [31:0] wd;
        case (sz)
            SZ_B:    wd = {4{sd[7:0]}};
            SZ_H:    wd = {2{sd[15:0]}};
            default: wd = sd;
        endcase
        return wd;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0]  op,
                                                input logic [1:0]  off,
                                                input logic [31:0] rdata);
        logic [7:0]         b;
        logic [15:0]        h;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic [31:0]        res;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h  = off[1] ? rdata[31:16] : rdata[15:0];
        sb = b;
        sh = h;
        case (op)
            LD_LB:   res = 32'(sb);
            LD_LH:   res = 32'(sh);
            LD_LBU:  res = 32'(b);
            LD_LHU:  res = 32'(h);
            default: res = rdata;
        endcase
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // Input decode
    // -----------------------------------------------------------------------
    logic       is_load_in;
    logic       is_store_in;
    logic       mem_op_in;
    logic [1:0] size_in;
    logic       mis_in;

    always_comb begin
        is_load_in  = (in_mem_read >= LD_LB) && (in_mem_read <= LD_LHU);
        // A load in the same instruction overrides any store request.
        is_store_in = !is_load_in && (in_mem_write != ST_NONE);
        mem_op_in   = is_load_in || is_store_in;
        size_in     = SZ_W;
        if (is_load_in) begin
            if (in_mem_read == LD_LB || in_mem_read == LD_LBU)
                size_in = SZ_B;
            else if (in_mem_read == LD_LH || in_mem_read == LD_LHU)
                size_in = SZ_H;
        end else begin
            if (in_mem_write == ST_SB)
                size_in = SZ_B;
            else if (in_mem_write == ST_SH)
                size_in = SZ_H;
        end
        mis_in = ((size_in == SZ_H) && in_alu_res[0]) ||
                 ((size_in == SZ_W) && (in_alu_res[1:0] != 2'b00));
    end

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    state_t      state;
    state_t      state_n;
    logic        pass_thru;
    logic        fault_mis;
    logic        go_bus;
    logic        done_ack;
    logic        done_to;
    logic [31:0] cnt_p0;
    logic        timeout_hit;

    // The counter holds the number of BUS cycles already completed, so the
    // abort fires at the end of the TIMEOUT_CYCLES-th BUS cycle.
    assign timeout_hit = TO_EN && ((cnt_p0 + 32'd1) == TO_LIMIT);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        pass_thru = 1'b0;
        fault_mis = 1'b0;
        go_bus    = 1'b0;
        done_ack  = 1'b0;
        done_to   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (!mem_op_in) begin
                        pass_thru = 1'b1;
                    end else if (mis_in) begin
                        fault_mis = 1'b1;
                    end else begin
                        go_bus  = 1'b1;
                        state_n = BUS;
                    end
                end
            end
            BUS: begin
                if (dbus_ack) begin
                    done_ack = 1'b1;
                    state_n  = IDLE;
                end else if (timeout_hit) begin
                    done_to = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign stall    = (state == BUS);
    assign dbus_req = (state == BUS);

    // -----------------------------------------------------------------------
    // Stage p0: transaction latched at acceptance, held through BUS
    // -----------------------------------------------------------------------
    logic [2:0]  ld_op_p0;
    logic        isld_p0;
    logic [1:0]  off_p0;
    logic [31:0] addr_p0;
    logic        we_p0;
    logic [3:0]  be_p0;
    logic [31:0] wdata_p0;
    logic [31:0] alu_p0;
    logic [31:0] pc_p0;
    logic [4:0]  rd_p0;
    logic        regw_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_op_p0 <= '0;
            isld_p0  <= 1'b0;
            off_p0   <= '0;
            addr_p0  <= '0;
            we_p0    <= 1'b0;
            be_p0    <= '0;
            wdata_p0 <= '0;
            alu_p0   <= '0;
            pc_p0    <= '0;
            rd_p0    <= '0;
            regw_p0  <= 1'b0;
            cnt_p0   <= '0;
        end else begin
            if (go_bus) begin
                ld_op_p0 <= in_mem_read;
                isld_p0  <= is_load_in;
                off_p0   <= in_alu_res[1:0];
                addr_p0  <= {in_alu_res[31:2], 2'b00};
                we_p0    <= is_store_in;
                be_p0    <= is_load_in ? 4'b1111 : store_be(size_in, in_alu_res[1:0]);
                wdata_p0 <= is_load_in ? 32'h0 : store_wdata(size_in, in_store_data);
                alu_p0   <= in_alu_res;
                pc_p0    <= in_pc;
                rd_p0    <= in_rd;
                regw_p0  <= in_reg_write;
                cnt_p0   <= '0;
            end else if (state == BUS) begin
                cnt_p0 <= cnt_p0 + 32'd1;
            end
        end
    end

    assign dbus_we    = we_p0;
    assign dbus_be    = be_p0;
    assign dbus_addr  = addr_p0;
    assign dbus_wdata = wdata_p0;

    // -----------------------------------------------------------------------
    // Stage p1: writeback outputs
    // -----------------------------------------------------------------------
    logic        vld_p1;
    logic        isld_p1;
    logic [31:0] mdata_p1;
    logic [31:0] alu_p1;
    logic [31:0] pc_p1;
    logic [4:0]  rd_p1;
    logic        regw_p1;
    logic        mis_p1;
    logic        berr_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            isld_p1  <= 1'b0;
            mdata_p1 <= '0;
            alu_p1   <= '0;
            pc_p1    <= '0;
            rd_p1    <= '0;
            regw_p1  <= 1'b0;
            mis_p1   <= 1'b0;
            berr_p1  <= 1'b0;
        end else begin
            vld_p1  <= 1'b0;
            mis_p1  <= 1'b0;
            berr_p1 <= 1'b0;
            if (pass_thru || fault_mis) begin
                vld_p1   <= 1'b1;
                isld_p1  <= 1'b0;
                mdata_p1 <= '0;
                alu_p1   <= in_alu_res;
                pc_p1    <= in_pc;
                rd_p1    <= in_rd;
                regw_p1  <= in_reg_write && !fault_mis;
                mis_p1   <= fault_mis;
            end else if (done_ack || done_to) begin
                vld_p1   <= 1'b1;
                isld_p1  <= isld_p0 && done_ack;
                mdata_p1 <= (isld_p0 && done_ack) ? load_extend(ld_op_p0, off_p0, dbus_rdata) : 32'h0;
                alu_p1   <= alu_p0;
                pc_p1    <= pc_p0;
                rd_p1    <= rd_p0;
                regw_p1  <= regw_p0 && done_ack;
                berr_p1  <= done_to;
            end
        end
    end

    assign wb_valid     = vld_p1;
    assign wb_is_load   = isld_p1;
    assign wb_mem_data  = mdata_p1;
    assign wb_alu_res   = alu_p1;
    assign wb_pc        = pc_p1;
    assign wb_rd        = rd_p1;
    assign wb_reg_write = regw_p1;
    assign misalign     = mis_p1;
    assign bus_err      = berr_p1;

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
//
// Directed testbench for mem_access_stage with TIMEOUT_CYCLES = 4. Inputs
// are driven and outputs sampled on the falling clock edge; each scenario
// task carries its own hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [2:0]  in_mem_read;
    logic [1:0]  in_mem_write;
    logic        in_reg_write;
    logic [4:0]  in_rd;
    logic [31:0] in_alu_res;
    logic [31:0] in_store_data;
    logic [31:0] in_pc;
    logic        stall;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;
    logic        wb_valid;
    logic        wb_is_load;
    logic [31:0] wb_mem_data;
    logic [31:0] wb_alu_res;
    logic [31:0] wb_pc;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        misalign;
    logic        bus_err;

    int errors = 0;
    int checks = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_mem_read  (in_mem_read),
        .in_mem_write (in_mem_write),
        .in_reg_write (in_reg_write),
        .in_rd        (in_rd),
        .in_alu_res   (in_alu_res),
        .in_store_data(in_store_data),
        .in_pc        (in_pc),
        .stall        (stall),
        .dbus_req     (dbus_req),
        .dbus_we      (dbus_we),
        .dbus_addr    (dbus_addr),
        .dbus_wdata   (dbus_wdata),
        .dbus_be      (dbus_be),
        .dbus_rdata   (dbus_rdata),
        .dbus_ack     (dbus_ack),
        .wb_valid     (wb_valid),
        .wb_is_load   (wb_is_load),
        .wb_mem_data  (wb_mem_data),
        .wb_alu_res   (wb_alu_res),
        .wb_pc        (wb_pc),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .misalign     (misalign),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        in_valid      = 1'b0;
        in_mem_read   = 3'd0;
        in_mem_write  = 2'd0;
        in_reg_write  = 1'b0;
        in_rd         = 5'd0;
        in_alu_res    = 32'h0;
        in_store_data = 32'h0;
        in_pc         = 32'h0;
        dbus_rdata    = 32'h0;
        dbus_ack      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || stall !== 1'b0 || dbus_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: wb_valid=%b stall=%b dbus_req=%b, required 0 0 0", wb_valid, stall, dbus_req);
        end
        checks++;
        if (wb_alu_res !== 32'h0 || wb_mem_data !== 32'h0 || dbus_be !== 4'h0 || dbus_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: wb_alu_res=%h wb_mem_data=%h dbus_be=%h dbus_addr=%h, required all 0",
                     wb_alu_res, wb_mem_data, dbus_be, dbus_addr);
        end
    endtask

    task automatic test_passthrough();
        in_valid = 1'b1; in_alu_res = 32'h1234; in_pc = 32'h100; in_rd = 5'd5; in_reg_write = 1'b1;
        @(negedge clk);
        clear_inputs();
        checks++;
        if (wb_valid !== 1'b1 || wb_alu_res !== 32'h1234 || wb_pc !== 32'h100 || wb_is_load !== 1'b0) begin
            errors++;
            $display("FAIL pass_wb: valid=%b alu=%h pc=%h is_load=%b, required 1 1234 100 0",
                     wb_valid, wb_alu_res, wb_pc, wb_is_load);
        end
        checks++;
        if (wb_rd !== 5'd5 || wb_reg_write !== 1'b1 || dbus_req !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL pass_ctl: rd=%0d reg_write=%b req=%b stall=%b, required 5 1 0 0",
                     wb_rd, wb_reg_write, dbus_req, stall);
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL pass_pulse: wb_valid=%b, required 0", wb_valid);
        end
    endtask

    // Load at 0x1003, ack in the third BUS cycle with rdata 0x80FF_FF00.
    task automatic test_load_byte(input logic [2:0] op, input logic [31:0] exp, input string nm);
        int stalls;
        in_valid = 1'b1; in_mem_read = op; in_alu_res = 32'h1003; in_pc = 32'h200;
        in_rd = 5'd7; in_reg_write = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_mem_read = 3'd0;
        checks++;
        if (dbus_req !== 1'b1 || dbus_addr !== 32'h1000 || dbus_we !== 1'b0 || dbus_be !== 4'hF) begin
            errors++;
            $display("FAIL %s_bus: req=%b addr=%h we=%b be=%h, required 1 00001000 0 f",
                     nm, dbus_req, dbus_addr, dbus_we, dbus_be);
        end
        stalls = 0;
        for (int i = 0; i < 3; i++) begin
            if (stall) stalls++;
            if (i == 2) begin
                dbus_ack   = 1'b1;
                dbus_rdata = 32'h80FF_FF00;
            end
            @(negedge clk);
        end
        dbus_ack = 1'b0;
        checks++;
        if (stalls != 3 || stall !== 1'b0) begin
            errors++;
            $display("FAIL %s_stall: stall cycles=%0d stall_now=%b, required 3 0", nm, stalls, stall);
        end
        checks++;
        if (wb_valid !== 1'b1 || wb_mem_data !== exp || wb_is_load !== 1'b1 ||
            wb_reg_write !== 1'b1 || wb_rd !== 5'd7 || wb_pc !== 32'h200) begin
            errors++;
            $display("FAIL %s_wb: valid=%b data=%h is_load=%b regw=%b rd=%0d pc=%h, required 1 %h 1 1 7 200",
                     nm, wb_valid, wb_mem_data, wb_is_load, wb_reg_write, wb_rd, wb_pc, exp);
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0 || dbus_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_after: wb_valid=%b req=%b, required 0 0", nm, wb_valid, dbus_req);
        end
    endtask

    task automatic test_store_sh();
        in_valid = 1'b1; in_mem_write = 2'd2; in_alu_res = 32'h2002; in_store_data = 32'hABCD_1234;
        in_pc = 32'h300; in_rd = 5'd0;
        @(negedge clk);
        clear_inputs();
        checks++;
        if (dbus_req !== 1'b1 || dbus_we !== 1'b1 || dbus_be !== 4'b1100 ||
            dbus_wdata !== 32'h1234_1234 || dbus_addr !== 32'h2000) begin
            errors++;
            $display("FAIL sh_bus: req=%b we=%b be=%b wdata=%h addr=%h, required 1 1 1100 12341234 00002000",
                     dbus_req, dbus_we, dbus_be, dbus_wdata, dbus_addr);
        end
        dbus_ack = 1'b1;
        @(negedge clk);
        dbus_ack = 1'b0;
        checks++;
        if (wb_valid !== 1'b1 || wb_is_load !== 1'b0 || stall !== 1'b0 || dbus_req !== 1'b0 || wb_pc !== 32'h300) begin
            errors++;
            $display("FAIL sh_wb: valid=%b is_load=%b stall=%b req=%b pc=%h, required 1 0 0 0 300",
                     wb_valid, wb_is_load, stall, dbus_req, wb_pc);
        end
    endtask

    task automatic test_store_sb();
        in_valid = 1'b1; in_mem_write = 2'd1; in_alu_res = 32'h7001; in_store_data = 32'h1122_33AB;
        @(negedge clk);
        clear_inputs();
        checks++;
        if (dbus_we !== 1'b1 || dbus_be !== 4'b0010 || dbus_wdata !== 32'hABAB_ABAB || dbus_addr !== 32'h7000) begin
            errors++;
            $display("FAIL sb_bus: we=%b be=%b wdata=%h addr=%h, required 1 0010 abababab 00007000",
                     dbus_we, dbus_be, dbus_wdata, dbus_addr);
        end
        dbus_ack = 1'b1;
        @(negedge clk);
        dbus_ack = 1'b0;
        checks++;
        if (wb_valid !== 1'b1) begin
            errors++;
            $display("FAIL sb_wb: wb_valid=%b, required 1", wb_valid);
        end
    endtask

    // LH and SW together: the load wins. Halfword at 0x6002 of 0x8001_2345 -> 0xFFFF_8001.
    task automatic test_load_wins();
        in_valid = 1'b1; in_mem_read = 3'd2; in_mem_write = 2'd3; in_alu_res = 32'h6002;
        in_store_data = 32'hDEAD_BEEF; in_rd = 5'd9; in_reg_write = 1'b1;
        @(negedge clk);
        clear_inputs();
        checks++;
        if (dbus_req !== 1'b1 || dbus_we !== 1'b0 || dbus_be !== 4'hF) begin
            errors++;
            $display("FAIL lwins_bus: req=%b we=%b be=%h, required 1 0 f", dbus_req, dbus_we, dbus_be);
        end
        dbus_ack = 1'b1; dbus_rdata = 32'h8001_2345;
        @(negedge clk);
        dbus_ack = 1'b0;
        checks++;
        if (wb_valid !== 1'b1 || wb_mem_data !== 32'hFFFF_8001 || wb_is_load !== 1'b1) begin
            errors++;
            $display("FAIL lwins_wb: valid=%b data=%h is_load=%b, required 1 ffff8001 1",
                     wb_valid, wb_mem_data, wb_is_load);
        end
    endtask

    task automatic test_misalign();
        in_valid = 1'b1; in_mem_read = 3'd3; in_alu_res = 32'h3001; in_rd = 5'd4; in_reg_write = 1'b1;
        @(negedge clk);
        clear_inputs();
        checks++;
        if (dbus_req !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL mis_bus: req=%b stall=%b, required 0 0", dbus_req, stall);
        end
        checks++;
        if (wb_valid !== 1'b1 || misalign !== 1'b1 || wb_reg_write !== 1'b0 || wb_mem_data !== 32'h0) begin
            errors++;
            $display("FAIL mis_wb: valid=%b misalign=%b regw=%b data=%h, required 1 1 0 0",
                     wb_valid, misalign, wb_reg_write, wb_mem_data);
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0 || misalign !== 1'b0) begin
            errors++;
            $display("FAIL mis_after: valid=%b misalign=%b, required 0 0", wb_valid, misalign);
        end
    endtask

    task automatic test_timeout();
        int reqs;
        bit seen;
        in_valid = 1'b1; in_mem_read = 3'd3; in_alu_res = 32'h4000; in_rd = 5'd3; in_reg_write = 1'b1;
        @(negedge clk);
        clear_inputs();
        reqs = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (wb_valid) seen = 1'b1;
            else begin
                if (dbus_req) reqs++;
                @(negedge clk);
            end
        end
        checks++;
        if (!seen || reqs != 4) begin
            errors++;
            $display("FAIL to_req: wb_valid seen=%b req cycles=%0d, required 1 4", seen, reqs);
        end
        checks++;
        if (wb_valid !== 1'b1 || bus_err !== 1'b1 || wb_mem_data !== 32'h0 ||
            wb_reg_write !== 1'b0 || dbus_req !== 1'b0) begin
            errors++;
            $display("FAIL to_wb: valid=%b bus_err=%b data=%h regw=%b req=%b, required 1 1 0 0 0",
                     wb_valid, bus_err, wb_mem_data, wb_reg_write, dbus_req);
        end
        in_valid = 1'b1; in_alu_res = 32'h55; in_pc = 32'h404;
        @(negedge clk);
        clear_inputs();
        checks++;
        if (wb_valid !== 1'b1 || wb_alu_res !== 32'h55 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL to_next: valid=%b alu=%h bus_err=%b, required 1 55 0", wb_valid, wb_alu_res, bus_err);
        end
    endtask

    task automatic test_reset_in_bus();
        in_valid = 1'b1; in_mem_read = 3'd3; in_alu_res = 32'h5000; in_reg_write = 1'b1;
        @(negedge clk);
        clear_inputs();
        checks++;
        if (dbus_req !== 1'b1) begin
            errors++;
            $display("FAIL rbus_req: req=%b, required 1", dbus_req);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (dbus_req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL rbus_abort: req=%b stall=%b valid=%b, required 0 0 0", dbus_req, stall, wb_valid);
        end
        dbus_ack = 1'b1; dbus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        dbus_ack = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || stall !== 1'b0 || dbus_req !== 1'b0) begin
            errors++;
            $display("FAIL rbus_late_ack: valid=%b stall=%b req=%b, required 0 0 0", wb_valid, stall, dbus_req);
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL rbus_quiet: valid=%b, required 0", wb_valid);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_byte(3'd1, 32'hFFFF_FF80, "lb");
        test_load_byte(3'd4, 32'h0000_0080, "lbu");
        test_store_sh();
        test_store_sb();
        test_load_wins();
        test_misalign();
        test_timeout();
        test_reset_in_bus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Pipeline memory stage that sits between execute and writeback. It produces the mem_data, alu_res and pc values that writeback selects from. It issues load/store transactions on a word-addressed data bus using a req/ack handshake, extracts and extends load data, and builds store byte-enables. It stalls upstream while a bus transaction is outstanding, and flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 255, bus cycles to wait for dbus_ack before aborting with bus_err; 0 disables the timeout.

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
in_valid  input  1  execute-stage result present
in_mem_read  input  3  0 NO_OP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU; 6–7 treated as NO_OP
in_mem_write  input  2  0 NO_OP, 1 SB, 2 SH, 3 SW
in_reg_write  input  1  instruction writes rd
in_rd  input  5  destination register
in_alu_res  input  32  ALU result; also the memory byte address
in_store_data  input  32  rs2 value
in_pc  input  32  instruction pc
stall  output  1  upstream must hold its inputs
dbus_req  output  1  transaction request
dbus_we  output  1  1 = write
dbus_addr  output  32  word address: in_alu_res with bits [1:0] = 0
dbus_wdata  output  32  replicated store data
dbus_be  output  4  byte enables
dbus_rdata  input  32  read data, valid when dbus_ack = 1
dbus_ack  input  1  transaction complete
wb_valid  output  1  writeback inputs valid this cycle
wb_is_load  output  1  wb_mem_data is the result
wb_mem_data  output  32  extended load data
wb_alu_res  output  32  passed through
wb_pc  output  32  passed through
wb_rd  output  5  passed through
wb_reg_write  output  1  in_reg_write, forced 0 on any fault
misalign  output  1  fault flag, qualified by wb_valid
bus_err  output  1  timeout flag, qualified by wb_valid

Behaviour:
- Reset: state IDLE; all outputs and registers 0. A reset asserted during BUS drops dbus_req in the cycle after rst is sampled. No wb_valid is produced for the aborted operation.
- FSM states: IDLE and BUS. stall = (state == BUS).
- IDLE, in_valid = 1, no memory op: all wb_* outputs are registered, and wb_valid = 1 in the next cycle. Latency is 1.
- IDLE, in_valid = 1, memory op present:
  - Latch the op, address, store data and passthrough fields.
  - Check alignment. Halfword ops fault if addr[0] = 1. Word ops fault if addr[1:0] != 0.
  - Misaligned: no bus transaction. Next cycle gives wb_valid = 1, misalign = 1, wb_reg_write = 0, wb_mem_data = 0.
  - Aligned: go to BUS.
- If in_mem_read and in_mem_write are both non-NO_OP, the load wins and the write is ignored.
- BUS:
  - dbus_req = 1, with addr, we, wdata and be held stable until ack.
  - The ack may arrive in the first BUS cycle.
  - On the cycle dbus_ack = 1: capture and extend the data, go to IDLE. Next cycle wb_valid = 1 and wb_is_load = load.
  - Memory latency is acceptance at t, ack at t+k (k ≥ 1), wb_valid at t+k+1.
- Timeout: a cycle counter runs in BUS. If it reaches TIMEOUT_CYCLES without an ack:
  - dbus_req drops and state goes to IDLE.
  - Next cycle: wb_valid = 1, bus_err = 1, wb_reg_write = 0, wb_mem_data = 0.
  - The counter clears on entering BUS.
- dbus_ack while not in BUS is ignored.
- Store formatting:
  - SB: wdata = {4{sd[7:0]}}, be = 4'b0001 << addr[1:0].
  - SH: wdata = {2{sd[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011.
  - SW: wdata = sd, be = 4'b1111.
  - Loads: dbus_we = 0, be = 4'b1111.
- Load extraction: take the byte or halfword at addr[1:0] from dbus_rdata. LB/LH sign-extend; LBU/LHU zero-extend; LW is unmodified.
- wb_valid is a single-cycle pulse per accepted instruction. It is 0 when idle or when in_valid = 0.

Test Plan:
- Non-memory op, alu_res=0x1234, pc=0x100 -> next cycle wb_valid=1, wb_alu_res=0x1234, wb_pc=0x100, wb_is_load=0, no dbus_req.
- LB at addr 0x1003, ack after 3 cycles with rdata=0x80FF_FF00 -> dbus_addr=0x1000, stall held 3 cycles, wb_mem_data=0xFFFF_FF80. Repeat as LBU -> 0x0000_0080.
- SH at addr 0x2002, store_data=0xABCD_1234, ack in first BUS cycle -> dbus_we=1, dbus_be=4'b1100, dbus_wdata=0x1234_1234; wb_valid one cycle after ack.
- LW at addr 0x3001 -> no dbus_req; next cycle wb_valid=1, misalign=1, wb_reg_write=0.
- TIMEOUT_CYCLES=4, LW at 0x4000 with no ack -> dbus_req high exactly 4 cycles, then wb_valid=1, bus_err=1, wb_mem_data=0; a following op is accepted.
- rst pulsed during BUS -> dbus_req=0 next cycle, stall=0, no wb_valid; a late dbus_ack is ignored.
